// File: rtl/v33_bus_responder_if.sv
// V33 external bus signals between the CPU bus control unit (master) and a target (slave).
// Carries the cycle status, address/data lanes, ready handshake and interrupt/halt sideband.
interface v33_bus_responder_if;
    logic        n_bcyst;
    logic        n_dstb;
    logic        r_w;
    logic        m_io;
    logic        busst1;
    logic        busst0;
    logic        n_ube;
    logic [23:0] addr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        n_ready;
    logic [7:0]  int_vector;
    logic        int_ack;
    logic        halt_ack;

    modport master (
        output n_bcyst, n_dstb, r_w, m_io, busst1, busst0, n_ube, addr, dout, int_vector,
        input  din, n_ready, int_ack, halt_ack
    );

    modport slave (
        input  n_bcyst, n_dstb, r_w, m_io, busst1, busst0, n_ube, addr, dout, int_vector,
        output din, n_ready, int_ack, halt_ack
    );
endinterface

// File: rtl/v33_bus_responder.sv
// Target end of the V33 bus: serves fetch/memory cycles from a 16-bit RAM, I/O, INTA and HALT.
// Optional I/O register file enabled by defining BUS_RESPONDER_IO_EN.
module v33_bus_responder #(
    parameter int MEM_AW   = 10,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    ce_1,
    input  logic                    ce_2,
    v33_bus_responder_if.slave      bus
);

    localparam int         RAM_WORDS  = 1 << MEM_AW;
    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_e;

    typedef enum logic [2:0] {
        CY_NULL, CY_FETCH, CY_MREAD, CY_MWRITE, CY_INTA, CY_IOREAD, CY_IOWRITE, CY_HALT
    } cycle_e;

    // Status word is {m_io, busst1, busst0, r_w}.
    function automatic cycle_e decode(input logic [3:0] st);
        case (st)
            4'b1001: return CY_FETCH;
            4'b1011: return CY_MREAD;
            4'b1010: return CY_MWRITE;
            4'b0001: return CY_INTA;
            4'b0011: return CY_IOREAD;
            4'b0010: return CY_IOWRITE;
            4'b0110: return CY_HALT;
            default: return CY_NULL;
        endcase
    endfunction

    state_e          state_q, state_d;
    cycle_e          cyc_q, cyc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [MEM_AW:0] addr_q, addr_d;
    logic            n_ube_q, n_ube_d;
    logic [15:0]     din_q, din_d;
    logic            n_ready_q, n_ready_d;
    logic            inta_phase_q, inta_phase_d;
    logic            int_ack_q, int_ack_d;
    logic            halt_ack_q, halt_ack_d;

    logic [15:0]     ram_q [RAM_WORDS];

    cycle_e          cyc_in;
    cycle_e          rd_cyc;
    logic [MEM_AW:0] rd_addr;
    logic [15:0]     rd_data;
    logic [3:0]      wait_ld;
    logic            complete;
    logic            wr_fire;
    logic            ram_we_lo, ram_we_hi;
    logic            unused_addr_bits;

`ifdef BUS_RESPONDER_IO_EN
    logic [15:0]     io_q [8];
    logic            io_hi_q, io_hi_d;
    logic            rd_io_hi;
    logic            io_we_lo, io_we_hi;
`endif

    assign cyc_in  = decode({bus.m_io, bus.busst1, bus.busst0, bus.r_w});
    assign wait_ld = bus.m_io ? MEM_WAIT_C : IO_WAIT_C;

    // A zero-wait cycle answers at the latching ce_1, so reads look at the live bus while idle.
    assign rd_cyc  = (state_q == ST_IDLE) ? cyc_in : cyc_q;
    assign rd_addr = (state_q == ST_IDLE) ? bus.addr[MEM_AW:0] : addr_q;
`ifdef BUS_RESPONDER_IO_EN
    assign rd_io_hi = (state_q == ST_IDLE) ? (bus.addr[23:4] != '0) : io_hi_q;
`endif

    always_comb begin
        rd_data = 16'hffff;
        case (rd_cyc)
            CY_FETCH, CY_MREAD: rd_data = ram_q[rd_addr[MEM_AW:1]];
            CY_INTA:            rd_data = {8'hff, bus.int_vector};
`ifdef BUS_RESPONDER_IO_EN
            CY_IOREAD:          if (!rd_io_hi) rd_data = io_q[rd_addr[3:1]];
`endif
            default:            rd_data = 16'hffff;
        endcase
    end

    assign complete  = (state_q == ST_READY) && ce_2;
    assign wr_fire   = complete && !bus.n_dstb;
    assign ram_we_lo = wr_fire && (cyc_q == CY_MWRITE) && !addr_q[0];
    assign ram_we_hi = wr_fire && (cyc_q == CY_MWRITE) && !n_ube_q;

    // Only the RAM-index bits (and the I/O port-range bits) of the address matter.
    assign unused_addr_bits = ^bus.addr;

    always_comb begin
        // NOTE: every next-state value starts from its hold value so no branch infers a latch.
        state_d      = state_q;
        cyc_d        = cyc_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        n_ube_d      = n_ube_q;
        din_d        = din_q;
        n_ready_d    = n_ready_q;
        inta_phase_d = inta_phase_q;
        int_ack_d    = 1'b0;
        halt_ack_d   = 1'b0;
`ifdef BUS_RESPONDER_IO_EN
        io_hi_d      = io_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ce_1 && !bus.n_bcyst) begin
                    cyc_d   = cyc_in;
                    addr_d  = bus.addr[MEM_AW:0];
                    n_ube_d = bus.n_ube;
`ifdef BUS_RESPONDER_IO_EN
                    io_hi_d = (bus.addr[23:4] != '0);
`endif
                    if (wait_ld == 4'd0) begin
                        n_ready_d = 1'b0;
                        din_d     = rd_data;
                        state_d   = ST_READY;
                    end else begin
                        cnt_d   = wait_ld;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (ce_1) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d     = 4'd0;
                        n_ready_d = 1'b0;
                        din_d     = rd_data;
                        state_d   = ST_READY;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_READY: begin
                if (ce_2) begin
                    n_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                    if (cyc_q == CY_INTA) begin
                        int_ack_d    = inta_phase_q;
                        inta_phase_d = ~inta_phase_q;
                    end else begin
                        inta_phase_d = 1'b0;
                    end
                    halt_ack_d = (cyc_q == CY_HALT);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= CY_NULL;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            n_ube_q      <= 1'b1;
            din_q        <= 16'hffff;
            n_ready_q    <= 1'b1;
            inta_phase_q <= 1'b0;
            int_ack_q    <= 1'b0;
            halt_ack_q   <= 1'b0;
`ifdef BUS_RESPONDER_IO_EN
            io_hi_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            n_ube_q      <= n_ube_d;
            din_q        <= din_d;
            n_ready_q    <= n_ready_d;
            inta_phase_q <= inta_phase_d;
            int_ack_q    <= int_ack_d;
            halt_ack_q   <= halt_ack_d;
`ifdef BUS_RESPONDER_IO_EN
            io_hi_q      <= io_hi_d;
`endif
        end
    end

    // NOTE: the RAM array is deliberately left out of reset so it can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (ram_we_lo) ram_q[addr_q[MEM_AW:1]][7:0]  <= bus.dout[7:0];
        if (ram_we_hi) ram_q[addr_q[MEM_AW:1]][15:8] <= bus.dout[15:8];
    end

`ifdef BUS_RESPONDER_IO_EN
    // Ports at 0x10 and above fall outside the register file and drop writes.
    assign io_we_lo = wr_fire && (cyc_q == CY_IOWRITE) && !io_hi_q && !addr_q[0];
    assign io_we_hi = wr_fire && (cyc_q == CY_IOWRITE) && !io_hi_q && !n_ube_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 8; i++) io_q[i] <= 16'h0000;
        end else begin
            if (io_we_lo) io_q[addr_q[3:1]][7:0]  <= bus.dout[7:0];
            if (io_we_hi) io_q[addr_q[3:1]][15:8] <= bus.dout[15:8];
        end
    end
`endif

    assign bus.din      = din_q;
    assign bus.n_ready  = n_ready_q;
    assign bus.int_ack  = int_ack_q;
    assign bus.halt_ack = halt_ack_q;

endmodule
